// File: rtl/audio_sample_player_pkg.sv
// Shared definitions for the audio sample player: bus widths, the sample
// table (base address and length per sample) and the player state enum.
package audio_sample_player_pkg;

  localparam int ADDR_WIDTH  = 18;
  localparam int DATA_WIDTH  = 16;
  localparam int NUM_SAMPLES = 3;
  // Index counter must hold 65535 and the length must hold 65536.
  localparam int IDX_WIDTH   = 17;

  localparam logic [ADDR_WIDTH-1:0] SAMPLE_BASE [NUM_SAMPLES] =
    '{18'h00000, 18'h10000, 18'h14000};
  localparam logic [IDX_WIDTH-1:0]  SAMPLE_LEN  [NUM_SAMPLES] =
    '{17'h10000, 17'h04000, 17'h04000};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_PRESENT = 2'd3
  } player_state_e;

  function automatic logic sel_valid(input logic [1:0] sel);
    return (int'(sel) < NUM_SAMPLES);
  endfunction

  // Table lookups are written as a scan so an out-of-table select yields zero
  // rather than an out-of-range array access.
  function automatic logic [ADDR_WIDTH-1:0] sample_base(input logic [1:0] sel);
    logic [ADDR_WIDTH-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_SAMPLES; i++)
      if (int'(sel) == i) b = SAMPLE_BASE[i];
    return b;
  endfunction

  function automatic logic [IDX_WIDTH-1:0] sample_len(input logic [1:0] sel);
    logic [IDX_WIDTH-1:0] l;
    l = '0;
    for (int i = 0; i < NUM_SAMPLES; i++)
      if (int'(sel) == i) l = SAMPLE_LEN[i];
    return l;
  endfunction

endpackage

// File: rtl/audio_sample_player_addr_gen.sv
// sample_addr_gen: latches the selected sample's base and length, walks the
// index through the sample and drives the registered ROM address.
module sample_addr_gen
  import audio_sample_player_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [1:0]            sel,
  input  logic                  advance,
  input  logic                  restart,
  output logic                  last,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [IDX_WIDTH-1:0]  len_q, len_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // Next-state for latch, index and address; load, advance and restart are
  // mutually exclusive by construction in the controller.
  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    idx_d  = idx_q;
    addr_d = addr_q;
    if (load) begin
      base_d = sample_base(sel);
      len_d  = sample_len(sel);
      idx_d  = '0;
      addr_d = sample_base(sel);
    end else if (advance) begin
      idx_d  = idx_q + IDX_WIDTH'(1);
      addr_d = base_q + ADDR_WIDTH'(idx_q) + ADDR_WIDTH'(1);
    end else if (restart) begin
      idx_d  = '0;
      addr_d = base_q;
    end
  end

  // Base, length and index are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    base_q <= base_d;
    len_q  <= len_d;
    idx_q  <= idx_d;
  end

  // The ROM address is visible at the port, so it resets to zero.
  always_ff @(posedge clk) begin
    if (reset) addr_q <= '0;
    else       addr_q <= addr_d;
  end

  assign last = (idx_q == (len_q - IDX_WIDTH'(1)));
  assign addr = addr_q;

endmodule

// File: rtl/audio_sample_player.sv
// audio_sample_player: walks one sample's ROM address range, captures the
// one-cycle-latency ROM data and hands each sample to the codec over
// valid/ready. Optional feature macro: AUDIO_PLAYER_LOOP_EN adds the loop
// input, which restarts playback at the sample base instead of finishing.
module audio_sample_player
  import audio_sample_player_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            sample_sel,
  input  logic                  stop,
`ifdef AUDIO_PLAYER_LOOP_EN
  input  logic                  loop,
`endif
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  player_state_e                 state_q, state_d;
  logic signed [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic                          done_q, done_d;
  logic                          load, advance, restart, last;
  logic                          loop_req;

`ifdef AUDIO_PLAYER_LOOP_EN
  assign loop_req = loop;
`else
  assign loop_req = 1'b0;
`endif

  sample_addr_gen u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .sel     (sample_sel),
    .advance (advance),
    .restart (restart),
    .last    (last),
    .addr    (rom_addr)
  );

  // Playback FSM; stop overrides every transition and suppresses done.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    load        = 1'b0;
    advance     = 1'b0;
    restart     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && sel_valid(sample_sel)) begin
          load    = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        out_data_d  = rom_data;
        out_valid_d = 1'b1;
        state_d     = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (last) begin
            if (loop_req) begin
              restart = 1'b1;
              state_d = ST_FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            advance = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (stop) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      load        = 1'b0;
      advance     = 1'b0;
      restart     = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_audio_sample_player.sv
// Self-checking bench for audio_sample_player: a transaction-level model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_audio_sample_player;

`ifdef AUDIO_PLAYER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, stop, out_ready, loop_i;
  logic [1:0]  sel;
  logic [17:0] rom_addr;
  logic [15:0] rom_data, out_data;
  logic        out_valid, busy, done;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  audio_sample_player dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sample_sel (sel),
    .stop       (stop),
`ifdef AUDIO_PLAYER_LOOP_EN
    .loop       (loop_i),
`endif
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  // ROM content: every address gets a distinct word that also depends on the bank.
  function automatic logic [15:0] romf(input logic [17:0] a);
    return a[15:0] ^ {a[17:16], 14'h1A5B};
  endfunction

  always @(posedge clk) rom_data <= romf(rom_addr);

  int          hs_cnt = 0;
  int          done_cnt = 0;
  logic [17:0] last_hs_addr = '0;

  always @(posedge clk)
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      hs_cnt       <= hs_cnt + 1;
      last_hs_addr <= rom_addr;
    end

  always @(posedge clk)
    if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Reference: a playing sample is (base, length, position k); each sample
  // becomes valid two cycles after its address is issued and is retired by a
  // handshake.
  int tb_base [4] = '{32'h00000, 32'h10000, 32'h14000, 0};
  int tb_len  [4] = '{65536, 16384, 16384, 0};

  logic        m_busy = 1'b0, m_valid = 1'b0, m_done = 1'b0;
  logic [17:0] m_addr = '0, m_base = '0;
  int          m_len = 0, m_k = 0, m_wait = 0;

  always @(posedge clk) begin : model
    logic        nb, nv, nd;
    logic [17:0] na, nbase;
    int          nlen, nk, nw;
    nb = m_busy; nv = m_valid; nd = 1'b0; na = m_addr; nbase = m_base;
    nlen = m_len; nk = m_k; nw = m_wait;
    if (reset) begin
      nb = 1'b0; nv = 1'b0; na = '0; nk = 0; nw = 0;
    end else if (stop) begin
      nb = 1'b0; nv = 1'b0;
    end else if (!m_busy) begin
      if (start && int'(sel) < 3) begin
        nb = 1'b1; nbase = 18'(tb_base[sel]); nlen = tb_len[sel];
        nk = 0; na = nbase; nw = 2;
      end
    end else if (m_valid) begin
      if (out_ready) begin
        nv = 1'b0;
        if (m_k == m_len - 1) begin
          if (LOOP_EN && loop_i) begin
            nk = 0; na = m_base; nw = 2;
          end else begin
            nb = 1'b0; nd = 1'b1;
          end
        end else begin
          nk = m_k + 1; na = m_base + 18'(nk); nw = 2;
        end
      end
    end else begin
      nw = m_wait - 1;
      if (nw == 0) nv = 1'b1;
    end
    m_busy <= nb; m_valid <= nv; m_done <= nd; m_addr <= na;
    m_base <= nbase; m_len <= nlen; m_k <= nk; m_wait <= nw;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 20)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk)
    if (chk_en) begin
      check("model_rom_addr",  32'(rom_addr),  32'(m_addr));
      check("model_busy",      32'(busy),      32'(m_busy));
      check("model_out_valid", 32'(out_valid), 32'(m_valid));
      check("model_done",      32'(done),      32'(m_done));
      if (m_valid) check("model_out_data", 32'(out_data), 32'(romf(m_addr)));
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    int          h0, d0;
    bit          ok;
    logic [15:0] held;
    reset = 1'b1; start = 1'b0; stop = 1'b0; sel = 2'd0;
    out_ready = 1'b1; loop_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_rom_addr",  32'(rom_addr),  32'h0);
    check("reset_out_data",  32'(out_data),  32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_busy",      32'(busy),      32'h0);
    check("reset_done",      32'(done),      32'h0);
    reset = 1'b0;
    tick();

`ifndef AUDIO_PLAYER_LOOP_EN
    // Sample 1 end to end with the codec always ready.
    sel = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("s1_first_addr", 32'(rom_addr), 32'h10000);
    check("s1_busy_rise",  32'(busy),     32'h1);
    h0 = hs_cnt; d0 = done_cnt;
    wait_done(60000, "s1_done_timeout", ok);
    if (ok) begin
      check("s1_busy_at_done", 32'(busy), 32'h0);
      check("s1_handshakes",   32'(hs_cnt - h0), 32'd16384);
      check("s1_last_addr",    32'(last_hs_addr), 32'h13FFF);
      tick();
      check("s1_done_pulse", 32'(done), 32'h0);
      check("s1_done_count", 32'(done_cnt - d0), 32'd1);
    end
`endif

    // Sample 2: stall the 10th sample for five cycles; a start while busy is ignored.
    sel = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    h0 = hs_cnt;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (hs_cnt - h0 == 9 && out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("s2_reach_10th_timeout", 32'd0, 32'd1);
    out_ready = 1'b0;
    held = out_data;
    check("s2_stall_addr", 32'(rom_addr), 32'h14009);
    check("s2_stall_data", 32'(held),     32'h1A52);
    sel = 2'd0; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 1'b0;
      check("s2_hold_valid", 32'(out_valid), 32'h1);
      check("s2_hold_data",  32'(out_data),  32'(held));
      check("s2_hold_addr",  32'(rom_addr),  32'h14009);
    end
    out_ready = 1'b1;
    tick();
    check("s2_advance_addr", 32'(rom_addr), 32'h1400A);
    check("s2_handshakes",   32'(hs_cnt - h0), 32'd10);
    repeat (10) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("s2_stop_busy", 32'(busy), 32'h0);

    // Sample 0: stop on the 100th sample, coinciding with its handshake.
    sel = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    h0 = hs_cnt; d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (hs_cnt - h0 == 99 && out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("s0_reach_100th_timeout", 32'd0, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("s0_stop_valid", 32'(out_valid), 32'h0);
    check("s0_stop_busy",  32'(busy),      32'h0);
    repeat (3) tick();
    check("s0_stop_no_done", 32'(done_cnt - d0), 32'd0);
    sel = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("s0_restart_addr", 32'(rom_addr), 32'h00000);
    tick(); tick();
    check("s0_restart_valid", 32'(out_valid), 32'h1);
    check("s0_restart_data",  32'(out_data),  32'h1A5B);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Invalid select and start together with stop are both ignored.
    sel = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("bad_sel_busy", 32'(busy), 32'h0);
    sel = 2'd1; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", 32'(busy), 32'h0);
    tick();

`ifdef AUDIO_PLAYER_LOOP_EN
    // Loop on sample 1, then drop loop so the second pass finishes.
    loop_i = 1'b1; sel = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    h0 = hs_cnt; d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 60000; i++) begin
      tick();
      if (hs_cnt - h0 == 16384) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("loop_wrap_timeout", 32'd0, 32'd1);
    check("loop_wrap_addr", 32'(rom_addr), 32'h10000);
    check("loop_wrap_busy", 32'(busy),     32'h1);
    check("loop_no_done",   32'(done_cnt - d0), 32'd0);
    loop_i = 1'b0;
    wait_done(60000, "loop_end_timeout", ok);
    if (ok) begin
      check("loop_end_handshakes", 32'(hs_cnt - h0), 32'd32768);
      tick();
      check("loop_end_done_count", 32'(done_cnt - d0), 32'd1);
    end
`endif

    // Randomised traffic including a reset in the middle of playback.
    for (int i = 0; i < (LOOP_EN ? 600 : 15000); i++) begin
      out_ready = 1'($urandom_range(0, 1));
      start     = ($urandom_range(0, 15) == 0);
      sel       = 2'($urandom_range(0, 3));
      stop      = ($urandom_range(0, 299) == 0);
      reset     = (i == (LOOP_EN ? 300 : 7000));
      if (LOOP_EN) loop_i = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0; stop = 1'b1; reset = 1'b0; loop_i = 1'b0;
    tick();
    stop = 1'b0;
    tick();
    check("final_idle", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
